// File: rtl/andy_anim_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : andy_anim_ctrl
//  Purpose  : Per-character animation sequencer for Andy. Turns key intent,
//             hit events and game state into the registered state/frame pair
//             used by the sprite block, plus move/attack/block/KO signals.
//  Ports    : Clk, Reset_n (async, active-low), frame_clk (async ~60 Hz),
//             game_state[7:0], key_left/right/attack/defend, hit_in, hp_zero
//             -> character1_state[7:0], frame_num[7:0], move_l, move_r,
//             attack_hit, blocked (1-Clk strobes), die1, die_done (levels)
//  Revision : 1.0  initial release
// ============================================================================
module andy_anim_ctrl #(
    parameter int STAND_FRAMES   = 8,
    parameter int FORWARD_FRAMES = 5,
    parameter int BACK_FRAMES    = 5,
    parameter int ATTACK_FRAMES  = 9,
    parameter int ATTACK_HIT     = 4,
    parameter int HURT_FRAMES    = 4,
    parameter int DIE_FRAMES     = 12,
    parameter int FRAME_DIV      = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] game_state,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_attack,
    input  logic       key_defend,
    input  logic       hit_in,
    input  logic       hp_zero,
    output logic [7:0] character1_state,
    output logic [7:0] frame_num,
    output logic       move_l,
    output logic       move_r,
    output logic       attack_hit,
    output logic       blocked,
    output logic       die1,
    output logic       die_done
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int c_MAX_FRAMES = max2(max2(max2(STAND_FRAMES, FORWARD_FRAMES),
                                            max2(BACK_FRAMES, ATTACK_FRAMES)),
                                       max2(HURT_FRAMES, DIE_FRAMES));
    localparam int c_FW = (c_MAX_FRAMES > 1) ? $clog2(c_MAX_FRAMES) : 1;
    localparam int c_DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    typedef logic [c_FW-1:0] frame_t;
    typedef logic [c_DW-1:0] div_t;

    localparam frame_t c_STAND_LAST  = frame_t'(STAND_FRAMES - 1);
    localparam frame_t c_FWD_LAST    = frame_t'(FORWARD_FRAMES - 1);
    localparam frame_t c_BACK_LAST   = frame_t'(BACK_FRAMES - 1);
    localparam frame_t c_ATTACK_LAST = frame_t'(ATTACK_FRAMES - 1);
    localparam frame_t c_HURT_LAST   = frame_t'(HURT_FRAMES - 1);
    localparam frame_t c_DIE_LAST    = frame_t'(DIE_FRAMES - 1);
    localparam frame_t c_ATK_PRE     = frame_t'(ATTACK_HIT - 1);
    localparam div_t   c_DIV_LAST    = div_t'(FRAME_DIV - 1);

    typedef enum logic [2:0] {
        ST_STAND  = 3'd0,
        ST_ATTACK = 3'd1,
        ST_MOVEL  = 3'd2,
        ST_MOVER  = 3'd3,
        ST_HURT   = 3'd4,
        ST_DEFEND = 3'd5,
        ST_DIE    = 3'd6
    } state_t;

    // Registered state
    logic [1:0] r_sync_q;
    logic       r_fc_prev_q;
    logic       r_hit_prev_q;
    state_t     r_state_q;
    frame_t     r_frame_q;
    div_t       r_div_q;
    logic       r_pend_q;
    logic       r_move_l_q, r_move_r_q, r_attack_hit_q, r_blocked_q;
    logic       r_die1_q, r_die_done_q;

    // Next-state values
    state_t     w_state_d, w_next, w_key_state;
    frame_t     w_frame_d, w_last;
    div_t       w_div_d;
    logic       w_pend_d, w_restart;
    logic       w_move_l_d, w_move_r_d, w_attack_hit_d, w_blocked_d;
    logic       w_die1_d, w_die_done_d;

    logic w_tick, w_hit_rise, w_pend_eff, w_div_adv, w_locked;

    assign w_tick     = r_sync_q[1] & ~r_fc_prev_q;
    assign w_hit_rise = hit_in & ~r_hit_prev_q;
    // A hit edge arriving on the tick cycle itself still counts for that tick
    assign w_pend_eff = r_pend_q | w_hit_rise;
    assign w_div_adv  = (r_div_q == c_DIV_LAST);

    always_comb begin
        w_last = c_STAND_LAST;
        case (r_state_q)
            ST_ATTACK: w_last = c_ATTACK_LAST;
            ST_MOVEL:  w_last = c_BACK_LAST;
            ST_MOVER:  w_last = c_FWD_LAST;
            ST_HURT:   w_last = c_HURT_LAST;
            ST_DEFEND: w_last = '0;
            ST_DIE:    w_last = c_DIE_LAST;
            default:   w_last = c_STAND_LAST;
        endcase
    end

    // One-shots hold until the advance out of their last frame
    assign w_locked = ((r_state_q == ST_ATTACK) || (r_state_q == ST_HURT)) &&
                      !(w_div_adv && (r_frame_q == w_last));

    always_comb begin
        w_key_state = ST_STAND;
        if (key_defend)                  w_key_state = ST_DEFEND;
        else if (key_attack)             w_key_state = ST_ATTACK;
        else if (key_right && !key_left) w_key_state = ST_MOVER;
        else if (key_left && !key_right) w_key_state = ST_MOVEL;
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_frame_d      = r_frame_q;
        w_div_d        = r_div_q;
        w_pend_d       = w_pend_eff;
        w_next         = r_state_q;
        w_restart      = 1'b0;
        w_move_l_d     = 1'b0;
        w_move_r_d     = 1'b0;
        w_attack_hit_d = 1'b0;
        w_blocked_d    = 1'b0;
        if (w_tick) begin
            w_pend_d = 1'b0;
            if (game_state != 8'd1) begin
                w_state_d = ST_STAND;
                w_frame_d = '0;
                w_div_d   = '0;
            end else begin
                if (hp_zero || (r_state_q == ST_DIE)) begin
                    w_next = ST_DIE;
                end else if (w_pend_eff && (r_state_q != ST_HURT) && (r_state_q != ST_DEFEND)) begin
                    w_next = ST_HURT;
                end else if (w_pend_eff && (r_state_q == ST_DEFEND)) begin
                    w_next      = ST_DEFEND;
                    w_blocked_d = 1'b1;
                end else if (w_locked) begin
                    w_next = r_state_q;
                end else begin
                    w_next = w_key_state;
                    // A finished one-shot always starts over, even attack->attack
                    w_restart = (r_state_q == ST_ATTACK) || (r_state_q == ST_HURT);
                end

                if ((w_next != r_state_q) || w_restart || (w_next == ST_DEFEND)) begin
                    w_frame_d = '0;
                    w_div_d   = '0;
                end else begin
                    w_div_d = w_div_adv ? '0 : r_div_q + 1'b1;
                    if (w_div_adv) begin
                        if (r_frame_q != w_last)
                            w_frame_d = r_frame_q + 1'b1;
                        else if (r_state_q != ST_DIE)
                            w_frame_d = '0;
                    end
                    w_attack_hit_d = (r_state_q == ST_ATTACK) && w_div_adv &&
                                     (r_frame_q == c_ATK_PRE);
                end
                w_state_d  = w_next;
                w_move_l_d = (w_next == ST_MOVEL);
                w_move_r_d = (w_next == ST_MOVER);
            end
        end
        w_die1_d     = (w_state_d == ST_DIE);
        w_die_done_d = w_die1_d && (w_frame_d == c_DIE_LAST);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync_q       <= '0;
            r_fc_prev_q    <= 1'b0;
            r_hit_prev_q   <= 1'b0;
            r_state_q      <= ST_STAND;
            r_frame_q      <= '0;
            r_div_q        <= '0;
            r_pend_q       <= 1'b0;
            r_move_l_q     <= 1'b0;
            r_move_r_q     <= 1'b0;
            r_attack_hit_q <= 1'b0;
            r_blocked_q    <= 1'b0;
            r_die1_q       <= 1'b0;
            r_die_done_q   <= 1'b0;
        end else begin
            r_sync_q       <= {r_sync_q[0], frame_clk};
            r_fc_prev_q    <= r_sync_q[1];
            r_hit_prev_q   <= hit_in;
            r_state_q      <= w_state_d;
            r_frame_q      <= w_frame_d;
            r_div_q        <= w_div_d;
            r_pend_q       <= w_pend_d;
            r_move_l_q     <= w_move_l_d;
            r_move_r_q     <= w_move_r_d;
            r_attack_hit_q <= w_attack_hit_d;
            r_blocked_q    <= w_blocked_d;
            r_die1_q       <= w_die1_d;
            r_die_done_q   <= w_die_done_d;
        end
    end

    assign character1_state = {5'd0, r_state_q};
    assign frame_num        = 8'(r_frame_q);
    assign move_l           = r_move_l_q;
    assign move_r           = r_move_r_q;
    assign attack_hit       = r_attack_hit_q;
    assign blocked          = r_blocked_q;
    assign die1             = r_die1_q;
    assign die_done         = r_die_done_q;

endmodule
`default_nettype wire

// File: tb/tb_andy_anim_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_andy_anim_ctrl
//  Purpose  : Self-checking bench for andy_anim_ctrl. Stimulus pushes the
//             expected post-tick outputs into a queue; a monitor pops and
//             compares each time a frame tick reaches the outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_andy_anim_ctrl;

    localparam int FD = 4;
    localparam int N_STAND = 8, N_FWD = 5, N_BACK = 5, N_ATK = 9, ATK_HIT = 4;
    localparam int N_HURT = 4, N_DIE = 12;

    logic       Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
    logic [7:0] game_state = 8'd0;
    logic       key_left = 1'b0, key_right = 1'b0, key_attack = 1'b0, key_defend = 1'b0;
    logic       hit_in = 1'b0, hp_zero = 1'b0;
    logic [7:0] character1_state, frame_num;
    logic       move_l, move_r, attack_hit, blocked, die1, die_done;

    andy_anim_ctrl #(
        .STAND_FRAMES(N_STAND), .FORWARD_FRAMES(N_FWD), .BACK_FRAMES(N_BACK),
        .ATTACK_FRAMES(N_ATK), .ATTACK_HIT(ATK_HIT), .HURT_FRAMES(N_HURT),
        .DIE_FRAMES(N_DIE), .FRAME_DIV(FD)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .game_state(game_state),
        .key_left(key_left), .key_right(key_right), .key_attack(key_attack),
        .key_defend(key_defend), .hit_in(hit_in), .hp_zero(hp_zero),
        .character1_state(character1_state), .frame_num(frame_num),
        .move_l(move_l), .move_r(move_r), .attack_hit(attack_hit),
        .blocked(blocked), .die1(die1), .die_done(die_done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] st;
        logic [7:0] fr;
        logic [5:0] fl;   // {move_l, move_r, attack_hit, blocked, die1, die_done}
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: state plus ticks spent in it since entry
    int   m_st = 0;
    int   m_n  = 0;
    bit   m_pend = 0;

    function automatic void chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
        end
    endfunction

    function automatic int loop_len(input int s);
        case (s)
            0: return N_STAND;
            2: return N_BACK;
            3: return N_FWD;
            default: return 1;
        endcase
    endfunction

    function automatic exp_t model_step(input int gs, input bit l, input bit r,
                                        input bit a, input bit d, input bit hz);
        exp_t e;
        int   ks, fr;
        bit   blk, ah;
        blk = 0; ah = 0;
        ks = d ? 5 : a ? 1 : (r && !l) ? 3 : (l && !r) ? 2 : 0;
        if (gs != 1) begin
            m_st = 0; m_n = 0;
        end else if (hz || m_st == 6) begin
            if (m_st == 6) m_n++;
            else begin m_st = 6; m_n = 0; end
        end else if (m_pend && m_st != 4 && m_st != 5) begin
            m_st = 4; m_n = 0;
        end else if (m_pend && m_st == 5) begin
            blk = 1; m_n = 0;
        end else if ((m_st == 1 && m_n < N_ATK*FD - 1) || (m_st == 4 && m_n < N_HURT*FD - 1)) begin
            m_n++;
            ah = (m_st == 1) && (m_n == ATK_HIT*FD);
        end else begin
            if (ks == m_st && m_st != 1 && m_st != 4) m_n++;
            else begin m_st = ks; m_n = 0; end
        end
        m_pend = 0;
        case (m_st)
            1, 4:    fr = m_n / FD;
            5:       fr = 0;
            6:       fr = (m_n / FD > N_DIE - 1) ? N_DIE - 1 : m_n / FD;
            default: fr = (m_n / FD) % loop_len(m_st);
        endcase
        e.st = 8'(m_st);
        e.fr = 8'(fr);
        e.fl = {m_st == 2, m_st == 3, ah, blk, m_st == 6, (m_st == 6) && (fr == N_DIE - 1)};
        return e;
    endfunction

    task automatic do_tick(input int gs, input bit l, input bit r, input bit a,
                           input bit d, input bit hz, input bit hit);
        @(negedge Clk);
        game_state = 8'(gs);
        key_left = l; key_right = r; key_attack = a; key_defend = d; hp_zero = hz;
        if (hit) begin
            hit_in = 1'b1;
            @(negedge Clk);
            hit_in = 1'b0;
            m_pend = 1;
        end
        sb_q.push_back(model_step(gs, l, r, a, d, hz));
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_state"}, int'(character1_state), 0);
        chk({nm, "_frame"}, int'(frame_num), 0);
        chk({nm, "_flags"}, int'({move_l, move_r, attack_hit, blocked, die1, die_done}), 0);
    endtask

    // Monitor: each frame_clk rise becomes a DUT output update three Clk edges later
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk);
            repeat (3) @(posedge Clk);
            @(negedge Clk);
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("state", int'(character1_state), int'(e.st));
                chk("frame", int'(frame_num), int'(e.fr));
                chk("flags", int'({move_l, move_r, attack_hit, blocked, die1, die_done}), int'(e.fl));
            end
            @(negedge Clk);
            chk("strobe_width", int'({move_l, move_r, attack_hit, blocked}), 0);
        end
    end

    initial begin
        #2ms;
        chk("watchdog_timeout", 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        repeat (3) @(negedge Clk);
        check_reset_outputs("reset");
        Reset_n = 1'b1;

        // Walk right for 24 ticks: frames wrap 0..4 and one move_r per tick
        for (int i = 0; i < 24; i++) do_tick(1, 0, 1, 0, 0, 0, 0);
        // Attack for one tick, then idle until it completes and returns to stand
        do_tick(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 37; i++) do_tick(1, 0, 0, 0, 0, 0, 0);
        // Hit during attack frame 2, second hit inside hurt is discarded
        do_tick(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) do_tick(1, 0, 0, 0, 0, 0, 0);
        do_tick(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) do_tick(1, 0, 0, 0, 0, 0, (i == 5));
        // Defend absorbs a hit
        do_tick(1, 0, 0, 0, 1, 0, 0);
        do_tick(1, 0, 0, 0, 1, 0, 1);
        do_tick(1, 0, 0, 0, 1, 0, 0);
        // Left and right together stand still
        for (int i = 0; i < 3; i++) do_tick(1, 1, 1, 0, 0, 0, 0);
        // KO from mover: frame saturates at 11, stays dead after hp_zero drops
        for (int i = 0; i < 3; i++) do_tick(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 50; i++) do_tick(1, 0, 1, 0, 0, (i < 10), (i == 20));
        do_tick(0, 0, 0, 0, 0, 0, 0);
        do_tick(2, 1, 0, 0, 0, 0, 0);
        // Reset mid-attack at frame 5
        do_tick(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) do_tick(1, 0, 0, 0, 0, 0, 0);
        chk("pre_reset_frame", int'(frame_num), 5);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        m_st = 0; m_n = 0; m_pend = 0;
        @(negedge Clk);
        Reset_n = 1'b1;

        // Randomized play
        for (int i = 0; i < 300; i++) begin
            int gs;
            gs = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : 1;
            do_tick(gs, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0));
        end

        repeat (10) @(negedge Clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
